mmio_initiator: RTL

- Single-outstanding bus initiator for the peripheral bus (cs / we / address / write_data / read_data / ready).
- Accepts one access command at a time from a local command port and drives the bus.
- Holds cs until the responder asserts ready, then returns read data or a write acknowledge on a response port.
- Used by hardware sequencers, e.g. boot-time peripheral setup and self-test, to program cores without the CPU. Aborts with an error if a responder never answers.

---
 rtl/mmio_initiator.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mmio_initiator.sv
// mmio_initiator
// Single-outstanding peripheral-bus initiator. Takes one access command at a
// time from a local command port, drives cs/we/address/write_data, holds cs
// until the responder raises ready (or a wait-state timeout expires) and then
// reports the result as a one-cycle pulse on the response port.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake (cmd_ready high only in IDLE)
//   cmd_we/addr/wdata   command payload, sampled only in the accept cycle
//   rsp_valid           one-cycle pulse when an access finishes
//   rsp_rdata           captured read data (0 for writes and errors)
//   rsp_error           set with rsp_valid when the access timed out
//   busy                high whenever the initiator is not IDLE
//   cs/we/address/write_data  registered bus outputs
//   read_data/ready     responder return path (ready may be comb. from cs)
//
// Parameters:
//   TIMEOUT_CYCLES      max cycles cs is held without ready; 0 disables abort
//   CNT_WIDTH           wait counter width, 2**CNT_WIDTH > TIMEOUT_CYCLES
module mmio_initiator #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic        cs,
    output logic        we,
    output logic [7:0]  address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    input  logic        ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Counter value seen in the last permitted wait cycle; only meaningful
    // when the timeout is enabled.
    localparam logic [CNT_WIDTH-1:0] LAST_WAIT =
        (TIMEOUT_CYCLES == 0) ? {CNT_WIDTH{1'b0}} : CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state;
    logic [CNT_WIDTH-1:0] wait_cnt;

    // Access sequencer: owns the state, the wait counter and every output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= {CNT_WIDTH{1'b0}};
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            cs         <= 1'b0;
            we         <= 1'b0;
            address    <= 8'h00;
            write_data <= 32'h0000_0000;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0000_0000;
            rsp_error  <= 1'b0;
        end else begin
            // rsp_valid is a single-cycle pulse: it is only ever raised on the
            // ACCESS->RESP transition and falls on the following edge.
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        we         <= cmd_we;
                        address    <= cmd_addr;
                        write_data <= cmd_wdata;
                        cs         <= 1'b1;
                        wait_cnt   <= {CNT_WIDTH{1'b0}};
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end else begin
                        cmd_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                ACCESS: begin
                    // ready is checked first so a completion in the final
                    // permitted cycle beats the timeout.
                    if (ready) begin
                        rsp_rdata <= we ? 32'h0000_0000 : read_data;
                        rsp_error <= 1'b0;
                        rsp_valid <= 1'b1;
                        cs        <= 1'b0;
                        we        <= 1'b0;
                        state     <= RESP;
                    end else if (TIMEOUT_EN && (wait_cnt == LAST_WAIT)) begin
                        rsp_rdata <= 32'h0000_0000;
                        rsp_error <= 1'b1;
                        rsp_valid <= 1'b1;
                        cs        <= 1'b0;
                        we        <= 1'b0;
                        state     <= RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        // Saturates only in the no-timeout configuration.
                        wait_cnt  <= wait_cnt + CNT_ONE;
                    end else begin
                        wait_cnt  <= wait_cnt;
                    end
                end
                RESP: begin
                    // cs stays low here, guaranteeing a gap between accesses.
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    cs        <= 1'b0;
                    we        <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
